rsd_mem_responder: RTL and testbench

- Memory-side responder for the core's memory access interface.
- Accepts read/write requests driven by the core (memAccessAddr/WriteData/RE/WE).
- Issues request serials and applies backpressure through the busy flags.
- Returns read data in order after a fixed latency and acknowledges writes with a tagged response; contains the backing word array. Replaces the flat memory model under the core top.

---
 rtl/rsd_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_rsd_mem_responder.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsd_mem_responder.sv
// Memory-side responder for the core's memory access port: in-order fixed-latency reads through
// an age-tracked FIFO, a single outstanding write with a tagged acknowledge, and the backing array.
module rsd_mem_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int SERIAL_WIDTH  = 4,
    parameter int MEM_WORDS     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   memAccessAddr,
    input  logic [DATA_WIDTH-1:0]   memAccessWriteData,
    input  logic                    memAccessRE,
    input  logic                    memAccessWE,
    output logic [SERIAL_WIDTH-1:0] nextMemReadSerial,
    output logic [SERIAL_WIDTH-1:0] nextMemWriteSerial,
    output logic [DATA_WIDTH-1:0]   memReadData,
    output logic                    memReadDataReady,
    output logic [SERIAL_WIDTH-1:0] memReadSerial,
    output logic [SERIAL_WIDTH:0]   memAccessResponse,
    output logic                    memAccessReadBusy,
    output logic                    memAccessWriteBusy
);

    localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);
    localparam int INDEX_W  = $clog2(MEM_WORDS);
    localparam int PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
    localparam int AGE_W    = $clog2(READ_LATENCY + 1);
    localparam int WAGE_W   = $clog2(WRITE_LATENCY + 1);

    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(READ_LATENCY);
    localparam logic [AGE_W-1:0]  AGE_POP   = AGE_W'(READ_LATENCY - 1);
    localparam logic [WAGE_W-1:0] WAGE_LAST = WAGE_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(QUEUE_DEPTH);

    // Configuration guards evaluated at elaboration.
    if (QUEUE_DEPTH > (1 << SERIAL_WIDTH)) begin : gen_bad_serial_space
        $error("QUEUE_DEPTH must not exceed 2**SERIAL_WIDTH");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end
    if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : gen_bad_words
        $error("MEM_WORDS must be a power of two");
    end
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : gen_bad_latency
        $error("latencies must be at least 1");
    end

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_WAIT = 2'd1,
        WR_RESP = 2'd2
    } wrState_t;

    // Backing array and read FIFO payload (not reset).
    logic [DATA_WIDTH-1:0]   mem     [MEM_WORDS];
    logic [DATA_WIDTH-1:0]   dataQ   [QUEUE_DEPTH];
    logic [SERIAL_WIDTH-1:0] serialQ [QUEUE_DEPTH];

    logic [AGE_W-1:0]        ageQ    [QUEUE_DEPTH];
    logic [PTR_W-1:0]        wrPtr;
    logic [PTR_W-1:0]        rdPtr;
    logic [CNT_W-1:0]        readCount;
    logic [SERIAL_WIDTH-1:0] readSerial;
    logic [SERIAL_WIDTH-1:0] writeSerial;

    wrState_t                wrState;
    wrState_t                wrStateNext;
    logic [WAGE_W-1:0]       wrAge;
    logic [WAGE_W-1:0]       wrAgeNext;
    logic [SERIAL_WIDTH-1:0] wrSerial;

    logic [INDEX_W-1:0]      accIndex;
    logic                    readAccept;
    logic                    writeAccept;
    logic                    readPop;
    logic                    unusedAddrBits;

    assign accIndex       = memAccessAddr[OFFSET_W +: INDEX_W];
    assign unusedAddrBits = ^{memAccessAddr[ADDR_WIDTH-1:OFFSET_W+INDEX_W], memAccessAddr[OFFSET_W-1:0]};

    // Handshake: a request is taken on a rising edge where its enable is high and the matching
    // busy is low; while busy is high the core holds the request and nothing changes here.
    assign memAccessReadBusy  = (readCount == CNT_FULL);
    assign memAccessWriteBusy = (wrState != WR_IDLE);
    assign readAccept         = memAccessRE && !memAccessReadBusy;
    assign writeAccept        = memAccessWE && (wrState == WR_IDLE);
    assign readPop            = (readCount != '0) && (ageQ[rdPtr] >= AGE_POP);

    assign nextMemReadSerial  = readSerial;
    assign nextMemWriteSerial = writeSerial;
    assign memAccessResponse  = (wrState == WR_RESP) ? {1'b1, wrSerial} : '0;

    // Array access: the FIFO captures the pre-write word, giving read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (writeAccept) begin
            mem[accIndex] <= memAccessWriteData;
        end
        if (readAccept) begin
            dataQ[wrPtr]   <= mem[accIndex];
            serialQ[wrPtr] <= readSerial;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            readCount        <= '0;
            readSerial       <= '0;
            memReadDataReady <= 1'b0;
            memReadData      <= '0;
            memReadSerial    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                ageQ[i] <= '0;
            end
        end else begin
            // Free slots also age; they saturate and are cleared again when refilled.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (readAccept && (wrPtr == PTR_W'(i))) begin
                    ageQ[i] <= '0;
                end else if (ageQ[i] != AGE_MAX) begin
                    ageQ[i] <= ageQ[i] + 1'b1;
                end
            end

            if (readAccept) begin
                wrPtr      <= wrPtr + 1'b1;
                readSerial <= readSerial + 1'b1;
            end

            if (readPop) begin
                rdPtr            <= rdPtr + 1'b1;
                memReadDataReady <= 1'b1;
                memReadData      <= dataQ[rdPtr];
                memReadSerial    <= serialQ[rdPtr];
            end else begin
                memReadDataReady <= 1'b0;
                memReadData      <= '0;
                memReadSerial    <= '0;
            end

            case ({readAccept, readPop})
                2'b10:   readCount <= readCount + 1'b1;
                2'b01:   readCount <= readCount - 1'b1;
                default: readCount <= readCount;
            endcase
        end
    end

    // Write tracker: WAIT counts edges after acceptance, RESP is the single acknowledge cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrState     <= WR_IDLE;
            wrAge       <= '0;
            wrSerial    <= '0;
            writeSerial <= '0;
        end else begin
            wrState <= wrStateNext;
            wrAge   <= wrAgeNext;
            if (writeAccept) begin
                wrSerial    <= writeSerial;
                writeSerial <= writeSerial + 1'b1;
            end
        end
    end

    always_comb begin
        wrStateNext = wrState;
        wrAgeNext   = wrAge;
        case (wrState)
            WR_IDLE: begin
                if (memAccessWE) begin
                    wrStateNext = WR_WAIT;
                    wrAgeNext   = '0;
                end
            end
            WR_WAIT: begin
                if (wrAge == WAGE_LAST) begin
                    wrStateNext = WR_RESP;
                end else begin
                    wrAgeNext = wrAge + 1'b1;
                end
            end
            WR_RESP: begin
                wrStateNext = WR_IDLE;
            end
            default: begin
                wrStateNext = WR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rsd_mem_responder.sv
// Bench for rsd_mem_responder: random and directed traffic checked against a queue-based
// model of acceptance, latency, serial numbering and array contents.
module tb_rsd_mem_responder;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 4;
    localparam int MW = 1024;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] memAccessAddr;
    logic [DW-1:0] memAccessWriteData;
    logic          memAccessRE;
    logic          memAccessWE;
    logic [SW-1:0] nextMemReadSerial;
    logic [SW-1:0] nextMemWriteSerial;
    logic [DW-1:0] memReadData;
    logic          memReadDataReady;
    logic [SW-1:0] memReadSerial;
    logic [SW:0]   memAccessResponse;
    logic          memAccessReadBusy;
    logic          memAccessWriteBusy;

    rsd_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .MEM_WORDS(MW),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .memAccessAddr(memAccessAddr),
        .memAccessWriteData(memAccessWriteData),
        .memAccessRE(memAccessRE),
        .memAccessWE(memAccessWE),
        .nextMemReadSerial(nextMemReadSerial),
        .nextMemWriteSerial(nextMemWriteSerial),
        .memReadData(memReadData),
        .memReadDataReady(memReadDataReady),
        .memReadSerial(memReadSerial),
        .memAccessResponse(memAccessResponse),
        .memAccessReadBusy(memAccessReadBusy),
        .memAccessWriteBusy(memAccessWriteBusy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;
    int edgeNum  = 0;

    // Reference model state.
    logic [DW-1:0]    modelMem [MW];
    logic [SW+DW-1:0] exp_q[$];
    int               due_q[$];
    logic [SW-1:0]    rdSerial;
    logic [SW-1:0]    wrSerial;
    logic [SW-1:0]    wrSerialLatched;
    int               wrLast;

    logic             expReady;
    logic [SW-1:0]    expRdSerial;
    logic [DW-1:0]    expRdData;
    logic [SW:0]      expResp;
    logic             expRBusy;
    logic             expWBusy;

    function automatic int addr_index(input logic [AW-1:0] addr);
        return int'((addr / (DW / 8)) % MW);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        rdSerial        = '0;
        wrSerial        = '0;
        wrSerialLatched = '0;
        wrLast          = -1000;
    endtask

    // Driver: presents one cycle of inputs, advances the model over the edge, returns at the negedge.
    task automatic do_cycle(input logic re, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, output logic ra, output logic wa);
        int e;
        int idx;
        e   = edgeNum + 1;
        idx = addr_index(addr);
        ra  = re && (due_q.size() < QD);
        wa  = we && !(e <= wrLast + WL + 1);
        memAccessRE        = re;
        memAccessWE        = we;
        memAccessAddr      = addr;
        memAccessWriteData = wdata;
        @(posedge clk);
        edgeNum = e;
        if (ra) begin
            exp_q.push_back({rdSerial, modelMem[idx]});
            due_q.push_back(e + RL);
            rdSerial = rdSerial + 1'b1;
        end
        if (wa) begin
            modelMem[idx]   = wdata;
            wrLast          = e;
            wrSerialLatched = wrSerial;
            wrSerial        = wrSerial + 1'b1;
        end
        @(negedge clk);
        expReady    = 1'b0;
        expRdSerial = '0;
        expRdData   = '0;
        if (due_q.size() > 0 && due_q[0] == e) begin
            {expRdSerial, expRdData} = exp_q.pop_front();
            void'(due_q.pop_front());
            expReady = 1'b1;
        end
        expResp  = (e == wrLast + WL) ? {1'b1, wrSerialLatched} : '0;
        expWBusy = (e >= wrLast) && (e <= wrLast + WL);
        expRBusy = (due_q.size() == QD);
        memAccessRE = 1'b0;
        memAccessWE = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic ra;
        logic wa;
        wa = 1'b0;
        for (int t = 0; t < 20 && !wa; t++) begin
            do_cycle(1'b0, 1'b1, addr, data, ra, wa);
        end
        checks++;
        if (!wa) begin
            failures++;
            $display("FAIL write_word accept: addr %h never accepted within 20 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        logic ra;
        logic wa;
        repeat (n) do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        memAccessRE = 1'b0;
        memAccessWE = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            edgeNum++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic ra;
        logic wa;
        apply_reset();
        checks++;
        if ({memReadDataReady, memReadSerial, memAccessResponse, memAccessReadBusy,
             memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got rdy=%b ser=%h resp=%h rb=%b wb=%b nrs=%h nws=%h required all 0",
                     memReadDataReady, memReadSerial, memAccessResponse, memAccessReadBusy,
                     memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial);
        end
        checks++;
        if (memReadData !== '0) begin
            failures++;
            $display("FAIL reset data: got %h required 0", memReadData);
        end
        for (int c = 0; c < 20; c++) begin
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
            checks++;
            if ({memAccessResponse, memReadDataReady} !== {expResp, expReady}) begin
                failures++;
                $display("FAIL reset idle: cycle %0d resp=%h rdy=%b required resp=%h rdy=%b",
                         c, memAccessResponse, memReadDataReady, expResp, expReady);
            end
        end
    endtask

    task automatic test_write_read();
        logic          ra;
        logic          wa;
        logic [DW-1:0] wd;
        logic          seen;
        wd = {rand_word() >> 8, 8'hA5};
        do_cycle(1'b0, 1'b1, 32'h0000_0040, wd, ra, wa);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({memAccessWriteBusy, memAccessResponse, nextMemWriteSerial} !== {expWBusy, expResp, wrSerial}) begin
                failures++;
                $display("FAIL wr_ack: cycle %0d got wb=%b resp=%h nws=%h required wb=%b resp=%h nws=%h",
                         c, memAccessWriteBusy, memAccessResponse, nextMemWriteSerial, expWBusy, expResp, wrSerial);
            end
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
        end
        do_cycle(1'b1, 1'b0, 32'h0000_0040, '0, ra, wa);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
            checks++;
            if (memReadDataReady !== expReady) begin
                failures++;
                $display("FAIL wr_rd ready: cycle %0d got %b required %b", c, memReadDataReady, expReady);
            end
            if (memReadDataReady === 1'b1) begin
                seen = 1'b1;
                checks++;
                if ({memReadSerial, memReadData} !== {expRdSerial, wd}) begin
                    failures++;
                    $display("FAIL wr_rd data: got ser=%h data=%h required ser=%h data=%h",
                             memReadSerial, memReadData, expRdSerial, wd);
                end
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL wr_rd return: got no ready within 8 cycles, required one");
        end
    endtask

    task automatic test_backpressure();
        logic          ra;
        logic          wa;
        logic          sawBusy;
        int            accepted;
        logic [SW-1:0] base;
        logic [DW-1:0] words [6];
        logic [SW-1:0] gotSer[$];
        logic [DW-1:0] gotData[$];
        for (int k = 0; k < 6; k++) begin
            words[k] = rand_word();
            write_word(AW'(k * 16), words[k]);
        end
        idle(WL + 2);
        base     = rdSerial;
        accepted = 0;
        sawBusy  = 1'b0;
        for (int c = 0; c < 60 && (accepted < 6 || due_q.size() > 0); c++) begin
            do_cycle(accepted < 6, 1'b0, AW'(accepted * 16), '0, ra, wa);
            if (ra) accepted++;
            if (memAccessReadBusy === 1'b1) sawBusy = 1'b1;
            checks++;
            if ({memReadDataReady, memAccessReadBusy, nextMemReadSerial} !== {expReady, expRBusy, rdSerial}) begin
                failures++;
                $display("FAIL bp cycle: cycle %0d got rdy=%b rb=%b nrs=%h required rdy=%b rb=%b nrs=%h",
                         c, memReadDataReady, memAccessReadBusy, nextMemReadSerial, expReady, expRBusy, rdSerial);
            end
            if (memReadDataReady === 1'b1) begin
                gotSer.push_back(memReadSerial);
                gotData.push_back(memReadData);
            end
        end
        checks++;
        if (accepted != 6 || sawBusy !== 1'b1) begin
            failures++;
            $display("FAIL bp accept: got accepted=%0d busy_seen=%b required 6 and 1", accepted, sawBusy);
        end
        checks++;
        if (gotSer.size() != 6) begin
            failures++;
            $display("FAIL bp returns: got %0d returns required 6", gotSer.size());
        end
        for (int k = 0; k < gotSer.size() && k < 6; k++) begin
            checks++;
            if ({gotSer[k], gotData[k]} !== {base + SW'(k), words[k]}) begin
                failures++;
                $display("FAIL bp order: return %0d got ser=%h data=%h required ser=%h data=%h",
                         k, gotSer[k], gotData[k], base + SW'(k), words[k]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic ra;
        logic wa;
        logic [DW-1:0] got[$];
        write_word(32'h0000_0080, 128'h11);
        idle(WL + 2);
        do_cycle(1'b1, 1'b1, 32'h0000_0080, 128'h22, ra, wa);
        idle(WL + 2);
        do_cycle(1'b1, 1'b0, 32'h0000_0080, '0, ra, wa);
        for (int c = 0; c < 10; c++) begin
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
            checks++;
            if (memReadDataReady !== expReady) begin
                failures++;
                $display("FAIL rw_same ready: cycle %0d got %b required %b", c, memReadDataReady, expReady);
            end
            if (memReadDataReady === 1'b1) got.push_back(memReadData);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 128'h22) begin
            failures++;
            $display("FAIL rw_same second: got %0d returns, last data %h required 1 return of 22",
                     got.size(), (got.size() > 0) ? got[got.size()-1] : '0);
        end
    endtask

    task automatic test_same_cycle_first();
        logic ra;
        logic wa;
        logic [DW-1:0] got[$];
        write_word(32'h0000_0080, 128'h11);
        idle(WL + 2);
        do_cycle(1'b1, 1'b1, 32'h0000_0080, 128'h22, ra, wa);
        checks++;
        if ({memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial} !==
            {expRBusy, expWBusy, rdSerial, wrSerial}) begin
            failures++;
            $display("FAIL rw_same accept: got rb=%b wb=%b nrs=%h nws=%h required rb=%b wb=%b nrs=%h nws=%h",
                     memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
                     expRBusy, expWBusy, rdSerial, wrSerial);
        end
        for (int c = 0; c < RL + 2; c++) begin
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
            if (memReadDataReady === 1'b1) got.push_back(memReadData);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 128'h11) begin
            failures++;
            $display("FAIL rw_same old: got %0d returns, first data %h required 1 return of 11",
                     got.size(), (got.size() > 0) ? got[0] : '0);
        end
    endtask

    task automatic test_serial_wrap();
        logic          ra;
        logic          wa;
        logic [DW-1:0] v;
        int            accepted;
        int            gap;
        logic [SW-1:0] gotSer[$];
        logic [DW-1:0] gotData[$];
        apply_reset();
        v = rand_word();
        write_word(32'h0000_0040, v);
        idle(WL + 2);
        accepted = 0;
        gap      = 0;
        for (int c = 0; c < 200 && (accepted < 17 || due_q.size() > 0); c++) begin
            do_cycle(accepted < 17 && gap == 0, 1'b0, 32'h0000_4040, '0, ra, wa);
            if (ra) begin
                accepted++;
                gap = $urandom_range(0, 2);
            end else if (gap > 0) begin
                gap--;
            end
            checks++;
            if ({memReadDataReady, memAccessReadBusy} !== {expReady, expRBusy}) begin
                failures++;
                $display("FAIL wrap cycle: cycle %0d got rdy=%b rb=%b required rdy=%b rb=%b",
                         c, memReadDataReady, memAccessReadBusy, expReady, expRBusy);
            end
            if (memReadDataReady === 1'b1) begin
                gotSer.push_back(memReadSerial);
                gotData.push_back(memReadData);
            end
        end
        checks++;
        if (gotSer.size() != 17) begin
            failures++;
            $display("FAIL wrap count: got %0d returns required 17", gotSer.size());
        end
        for (int i = 0; i < gotSer.size() && i < 17; i++) begin
            checks++;
            if ({gotSer[i], gotData[i]} !== {SW'(i), v}) begin
                failures++;
                $display("FAIL wrap serial: return %0d got ser=%h data=%h required ser=%h data=%h",
                         i, gotSer[i], gotData[i], SW'(i), v);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic ra;
        logic wa;
        do_cycle(1'b1, 1'b0, 32'h0000_0000, '0, ra, wa);
        do_cycle(1'b1, 1'b0, 32'h0000_0010, '0, ra, wa);
        do_cycle(1'b1, 1'b1, 32'h0000_0020, rand_word(), ra, wa);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({memReadDataReady, memReadData, memReadSerial, memAccessResponse, memAccessReadBusy,
             memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial} !== '0) begin
            failures++;
            $display("FAIL midop async: got rdy=%b resp=%h wb=%b nrs=%h nws=%h required all 0",
                     memReadDataReady, memAccessResponse, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial);
        end
        model_reset();
        repeat (2) begin
            @(posedge clk);
            edgeNum++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            do_cycle(1'b0, 1'b0, '0, '0, ra, wa);
            checks++;
            if ({memReadDataReady, memAccessResponse, memAccessReadBusy, memAccessWriteBusy,
                 nextMemReadSerial, nextMemWriteSerial} !==
                {expReady, expResp, expRBusy, expWBusy, rdSerial, wrSerial}) begin
                failures++;
                $display("FAIL midop after: cycle %0d got rdy=%b resp=%h rb=%b wb=%b nrs=%h nws=%h required rdy=%b resp=%h rb=%b wb=%b nrs=%h nws=%h",
                         c, memReadDataReady, memAccessResponse, memAccessReadBusy, memAccessWriteBusy,
                         nextMemReadSerial, nextMemWriteSerial, expReady, expResp, expRBusy, expWBusy, rdSerial, wrSerial);
            end
        end
    endtask

    task automatic test_random();
        logic          ra;
        logic          wa;
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        for (int i = 0; i < 16; i++) begin
            write_word(AW'(i * 16), rand_word());
        end
        idle(WL + 2);
        for (int c = 0; c < 310; c++) begin
            re   = (c < 300) && ($urandom_range(0, 1) == 1);
            we   = (c < 300) && ($urandom_range(0, 3) == 0);
            addr = ($urandom() & ~32'h0000_3FF0) | AW'($urandom_range(0, 15) * 16);
            do_cycle(re, we, addr, rand_word(), ra, wa);
            checks++;
            if (memReadDataReady !== expReady) begin
                failures++;
                $display("FAIL rand ready: cycle %0d got %b required %b", c, memReadDataReady, expReady);
            end
            if (expReady) begin
                checks++;
                if ({memReadSerial, memReadData} !== {expRdSerial, expRdData}) begin
                    failures++;
                    $display("FAIL rand data: cycle %0d got ser=%h data=%h required ser=%h data=%h",
                             c, memReadSerial, memReadData, expRdSerial, expRdData);
                end
            end
            checks++;
            if ({memAccessResponse, memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial} !==
                {expResp, expRBusy, expWBusy, rdSerial, wrSerial}) begin
                failures++;
                $display("FAIL rand ctrl: cycle %0d got resp=%h rb=%b wb=%b nrs=%h nws=%h required resp=%h rb=%b wb=%b nrs=%h nws=%h",
                         c, memAccessResponse, memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial,
                         nextMemWriteSerial, expResp, expRBusy, expWBusy, rdSerial, wrSerial);
            end
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        memAccessAddr      = '0;
        memAccessWriteData = '0;
        memAccessRE        = 1'b0;
        memAccessWE        = 1'b0;
        model_reset();
        test_reset();
        test_write_read();
        test_backpressure();
        test_same_cycle_first();
        test_same_cycle();
        test_serial_wrap();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
